// File: rtl/msx_bus_pkg.sv
// rtl/msx_bus_pkg.sv - shared types and constants for the MSX slot bus master
package msx_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      TW,
      T3,
      DONE
   } bus_state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        write;
      logic        io;
      logic        m1;
      logic        slot;
   } bus_cmd_t;

   localparam logic [7:0] MSX_IO_MAPPER_PORT = 8'h8E;

endpackage

// File: rtl/msx_tstate_timer.sv
// rtl/msx_tstate_timer.sv - T-state phase counter with last-clock pulse
module msx_tstate_timer #(
   parameter int TDIV = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic last
);

   localparam int PW = $clog2(TDIV);
   localparam logic [PW-1:0] PH_LAST = PW'(TDIV - 1);

   logic [PW-1:0] phase;

   // phase restarts at 0 whenever the bus state changes, otherwise wraps every TDIV clocks
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         phase <= '0;
      end else if (phase == PH_LAST) begin
         phase <= '0;
      end else begin
         phase <= phase + PW'(1);
      end
   end

   assign last = (phase == PH_LAST);

endmodule

// File: rtl/msx_bus_master.sv
// rtl/msx_bus_master.sv - single-beat MSX cartridge-slot bus initiator
module msx_bus_master
   import msx_bus_pkg::*;
#(
   parameter int TDIV         = 8,
   parameter int IO_WAIT      = 1,
   parameter int WAIT_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   input  logic        cmd_write,
   input  logic        cmd_io,
   input  logic        cmd_m1,
   input  logic        cmd_slot,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] addr,
   output logic [7:0]  cdout,
   output logic        cdout_oe,
   input  logic [7:0]  cdin,
   output logic        merq_n,
   output logic        iorq_n,
   output logic        rd_n,
   output logic        wr_n,
   output logic        m1_n,
   output logic        sltsl_n,
   input  logic        wait_n
);

   bus_state_t state_q, state_d;
   bus_cmd_t   cmd_q, cmd_in;
   logic [7:0] mand_cnt, wait_cnt, mand_total, rdata_q;
   logic       err_q, t_last, restart, accept, more_mand, timeout_d;

   assign mand_total = cmd_q.io ? 8'(IO_WAIT) : 8'd0;
   assign more_mand  = (mand_cnt < mand_total);
   assign accept     = cmd_valid && (state_q == IDLE);
   assign restart    = (state_d != state_q);

   msx_tstate_timer #(.TDIV(TDIV)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .restart (restart),
      .last    (t_last)
   );

   // sanitise the incoming command: M1 only on memory reads, slot select only on memory cycles
   always_comb begin
      cmd_in       = '0;
      cmd_in.addr  = cmd_addr;
      cmd_in.wdata = cmd_wdata;
      cmd_in.write = cmd_write;
      cmd_in.io    = cmd_io;
      cmd_in.m1    = cmd_m1 & ~cmd_io & ~cmd_write;
      cmd_in.slot  = cmd_slot & ~cmd_io;
   end

   // bus state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decisions on T-state last clocks, plus bus strobe decode from the current state
   always_comb begin
      state_d   = state_q;
      timeout_d = 1'b0;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = rdata_q;
      addr      = cmd_q.addr;
      cdout_oe  = 1'b0;
      cdout     = 8'd0;
      merq_n    = 1'b1;
      iorq_n    = 1'b1;
      rd_n      = 1'b1;
      wr_n      = 1'b1;
      m1_n      = 1'b1;
      sltsl_n   = 1'b1;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) state_d = T1;
         end
         T1: begin
            if (t_last) state_d = T2;
         end
         T2: begin
            if (t_last) state_d = (mand_total != 8'd0 || !wait_n) ? TW : T3;
         end
         TW: begin
            if (t_last) begin
               if (more_mand) begin
                  state_d = TW;
               end else if (wait_n) begin
                  state_d = T3;
               end else if (wait_cnt == 8'(WAIT_TIMEOUT)) begin
                  state_d   = DONE;
                  timeout_d = 1'b1;
               end else begin
                  state_d = TW;
               end
            end
         end
         T3: begin
            if (t_last) state_d = DONE;
         end
         DONE: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_q == T1 || state_q == T2 || state_q == TW || state_q == T3) begin
         cdout_oe = cmd_q.write;
         cdout    = cmd_q.write ? cmd_q.wdata : 8'd0;
      end
      if (state_q == T2 || state_q == TW || state_q == T3) begin
         merq_n  = cmd_q.io;
         iorq_n  = ~cmd_q.io;
         sltsl_n = ~cmd_q.slot;
         rd_n    = cmd_q.write;
         wr_n    = ~cmd_q.write;
      end
      if (state_q == T1 || state_q == T2) begin
         m1_n = ~cmd_q.m1;
      end
   end

   // command latch, TW counters, timeout flag and read-data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_q    <= '0;
         mand_cnt <= 8'd0;
         wait_cnt <= 8'd0;
         err_q    <= 1'b0;
         rdata_q  <= 8'd0;
      end else begin
         if (accept) begin
            cmd_q    <= cmd_in;
            mand_cnt <= 8'd0;
            wait_cnt <= 8'd0;
            err_q    <= 1'b0;
         end
         if (t_last && state_d == TW) begin
            if (more_mand) begin
               mand_cnt <= mand_cnt + 8'd1;
            end else begin
               wait_cnt <= wait_cnt + 8'd1;
            end
         end
         if (timeout_d) err_q <= 1'b1;
         if (state_q == T3 && t_last && !cmd_q.write) rdata_q <= cdin;
      end
   end

endmodule
